vga_sync_generator: RTL
=======================

Name: vga_sync_generator

Overview:
- Generates 640x480@60 VGA raster timing from the 100 MHz system clock.
- Produces pixel_x, pixel_y and video_on, which drive the downstream image pixel controller's ROM addressing.
- Produces hsync and vsync for the VGA connector.
- Produces p_tick (pixel-rate qualifier) and frame_start for other display logic.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel; must be at least 2

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  asynchronous, active-low reset
- p_tick  out  1  pixel-rate qualifier, high 1 clk in every CLK_DIV
- pixel_x  out  10  current column, 0..H_TOTAL-1
- pixel_y  out  10  current line, 0..V_TOTAL-1
- video_on  out  1  high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- frame_start  out  1  1-clk pulse when the raster advances to (0,0)

Behaviour:
- Derived values:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK = 800
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK = 525
  - HS_START = H_DISPLAY+H_FRONT = 656; HS_END = HS_START+H_SYNC-1 = 751
  - VS_START = V_DISPLAY+V_FRONT = 490; VS_END = VS_START+V_SYNC-1 = 491
- Reset is asynchronous on reset_n low and applies immediately, including mid-frame. Reset values:
  - divider = 0, p_tick = 0
  - pixel_x = H_TOTAL-1 (799), pixel_y = V_TOTAL-1 (524)
  - video_on = 0, hsync = 1, vsync = 1, frame_start = 0
- Divider:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - p_tick = (divider == CLK_DIV-1), decoded combinationally from the register.
- Raster counters advance only on a clk edge where p_tick is high:
  - pixel_x == H_TOTAL-1: pixel_x wraps to 0 and pixel_y increments.
  - pixel_y == V_TOTAL-1 at that same wrap: pixel_y wraps to 0.
  - Otherwise pixel_x increments by 1.
  - Both counters hold at all other edges.
- hsync, vsync and video_on are registers:
  - Loaded on the same edge as the counters, from a decode of the next counter values.
  - They therefore always match the current pixel_x/pixel_y with zero lag.
  - hsync = 0 iff HS_START <= pixel_x <= HS_END.
  - vsync = 0 iff VS_START <= pixel_y <= VS_END.
- frame_start = p_tick and pixel_x == H_TOTAL-1 and pixel_y == V_TOTAL-1. It is high for exactly one clk per frame, in the cycle before the raster becomes (0,0).
- First frame after reset release:
  - p_tick is first high in the 4th clk cycle, with frame_start high in that same cycle.
  - At the 4th rising edge the raster becomes (0,0) and video_on becomes 1.
- Periods:
  - Line = H_TOTAL*CLK_DIV = 3200 clk.
  - Frame = 800*525*4 = 1,680,000 clk.
- Width rule: counters are 10 bits; H_TOTAL and V_TOTAL must be <= 1024. Wrap comparisons are exact equality; no overflow path exists.

Optional Feature:
- Macro: VGA_SYNC_DELAY_EN.
- Defined:
  - hsync, vsync and video_on pass through one extra register stage, loaded on p_tick edges only.
  - They lag pixel_x/pixel_y by exactly one pixel (CLK_DIV clk), to align with a registered ROM read downstream.
  - Delayed-stage reset values: 1, 1, 0.
  - pixel_x, pixel_y, p_tick and frame_start are unchanged.
- Undefined: zero-lag behaviour as specified above.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 default constants
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END
  - the counter width constant (10)
- One sub-module, pixel_tick_divider: the CLK_DIV counter with p_tick output, using the same clk and reset_n.

Test Plan:
- Reset: hold reset_n=0 for 5 clk -> pixel_x=799, pixel_y=524, hsync=1, vsync=1, video_on=0, p_tick=0, frame_start=0.
- Startup: release reset_n -> p_tick and frame_start high in cycle 4 only; after edge 4, pixel_x=0, pixel_y=0, video_on=1; p_tick then repeats every 4 clk.
- Line timing:
  - video_on falls when pixel_x goes 639->640.
  - hsync low exactly while pixel_x=656..751 (96 pixels = 384 clk).
  - pixel_x wraps 799->0 with pixel_y incrementing; line = 3200 clk.
- Frame timing:
  - vsync low only on lines 490..491.
  - video_on=0 for all of lines 480..524.
  - frame_start pulses exactly once per 1,680,000 clk.
- Mid-frame reset: assert reset_n=0 asynchronously at pixel (300,200) between clk edges -> all outputs take their reset values immediately; normal restart follows release.
- VGA_SYNC_DELAY_EN defined -> hsync falls one pixel after pixel_x reaches 656; video_on is 1 one pixel after (0,0); pixel_x/pixel_y are identical to the non-delayed build.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing defaults, derived raster constants and counter width.
package vga_timing_pkg;
    localparam int CNT_W          = 10;
    localparam int H_DISPLAY_DEF  = 640;
    localparam int H_FRONT_DEF    = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BACK_DEF     = 48;
    localparam int V_DISPLAY_DEF  = 480;
    localparam int V_FRONT_DEF    = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BACK_DEF     = 33;
    localparam int CLK_DIV_DEF    = 4;
    localparam int H_TOTAL        = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL        = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int HS_START       = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int HS_END         = HS_START + H_SYNC_DEF - 1;
    localparam int VS_START       = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int VS_END         = VS_START + V_SYNC_DEF - 1;

    function automatic logic in_span(input logic [CNT_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction
endpackage

// File: rtl/pixel_tick_divider.sv
// pixel_tick_divider: counts 0..CLK_DIV-1 and flags the last count as the pixel-rate tick.
module pixel_tick_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] D_MAX = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb div_d = (div_q == D_MAX) ? '0 : div_q + DW'(1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) div_q <= '0;
        else          div_q <= div_d;

    assign p_tick = (div_q == D_MAX);
endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: VGA raster counters, syncs and video_on from a divided pixel tick.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/video_on by one pixel for a registered ROM read.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int CLK_DIV   = CLK_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start
);
    localparam int HT  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int VT  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HSS = H_DISPLAY + H_FRONT;
    localparam int VSS = V_DISPLAY + V_FRONT;
    localparam logic [CNT_W-1:0] X_MAX = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(VT - 1);

    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             hs_q, hs_d, vs_q, vs_d, von_q, von_d;
    logic             x_wrap;

    pixel_tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .p_tick  (p_tick)
    );

    // Syncs decode the next counter values so they line up with pixel_x/pixel_y.
    always_comb begin
        x_wrap = p_tick && (x_q == X_MAX);
        x_d    = !p_tick ? x_q : (x_wrap ? '0 : x_q + CNT_W'(1));
        y_d    = !x_wrap ? y_q : ((y_q == Y_MAX) ? '0 : y_q + CNT_W'(1));
        hs_d   = !in_span(x_d, HSS, HSS + H_SYNC - 1);
        vs_d   = !in_span(y_d, VSS, VSS + V_SYNC - 1);
        von_d  = (int'(x_d) < H_DISPLAY) && (int'(y_d) < V_DISPLAY);
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            x_q   <= X_MAX;
            y_q   <= Y_MAX;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            von_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            von_q <= von_d;
        end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign frame_start = x_wrap && (y_q == Y_MAX);

`ifdef VGA_SYNC_DELAY_EN
    logic hs_dly_q, vs_dly_q, von_dly_q;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            hs_dly_q  <= 1'b1;
            vs_dly_q  <= 1'b1;
            von_dly_q <= 1'b0;
        end else if (p_tick) begin
            hs_dly_q  <= hs_q;
            vs_dly_q  <= vs_q;
            von_dly_q <= von_q;
        end

    assign hsync    = hs_dly_q;
    assign vsync    = vs_dly_q;
    assign video_on = von_dly_q;
`else
    assign hsync    = hs_q;
    assign vsync    = vs_q;
    assign video_on = von_q;
`endif
endmodule
